matmul_seq_ctrl: RTL and testbench
==================================

Name: matmul_seq_ctrl

Overview:
Sequential controller for the 4x4 matrix-multiply datapath.
- Accepts operands A then B as one element stream, buffers them, and computes C = A x B with a single shared multiply-accumulate unit sequenced by an internal FSM.
- Streams C out in row-major order.
- Sits between the host-side operand stream and the result consumer, replacing the fully combinational array with an area-cheap, time-multiplexed engine.

Parameters:
N, 4, matrix dimension (square N x N); N >= 2, power of two.
DATA_W, 8, unsigned element width of A and B.
OUT_W, 16, width of each output element of C.
ACC_W, 2*DATA_W+$clog2(N), internal accumulator width (derived; not overridden).

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand element valid.
in_ready  output  1  controller accepts an operand element this cycle.
in_data  input  DATA_W  operand element, unsigned.
out_valid  output  1  result element valid.
out_ready  input  1  consumer accepts a result element.
out_data  output  OUT_W  result element C[i][j].
out_last  output  1  high with the final element C[N-1][N-1].
busy  output  1  high in COMPUTE and OUTPUT states.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports clk, rst.
- Reset values, registered, effective at the first clk edge with rst=1:
  - state=LOAD_A; all counters = 0; accumulator = 0.
  - out_valid=0, out_last=0, out_data=0, busy=0.
  - in_ready=1 after reset releases. in_ready=0 while rst is high.
- States, in this order: LOAD_A -> LOAD_B -> COMPUTE -> OUTPUT -> LOAD_A.
- LOAD_A:
  - in_ready=1. Handshake is in_valid & in_ready.
  - Each beat writes A[r][c] in row-major order, index 0..N*N-1.
  - The beat carrying index N*N-1 transitions to LOAD_B.
- LOAD_B: same as LOAD_A for B. The last beat transitions to COMPUTE.
- COMPUTE:
  - in_ready=0; in_valid is ignored.
  - One MAC per cycle: acc <= (k==0 ? 0 : acc) + A[i][k]*B[k][j], with k fastest, then j, then i.
  - At k=N-1 the completed sum is written to C[i][j].
  - Lasts exactly N^3 cycles (64 at default). After the (N-1,N-1,N-1) step, transitions to OUTPUT.
- OUTPUT:
  - out_valid=1; out_data=C[i][j] in row-major order; out_last=1 at index N*N-1.
  - out_data and out_last hold stable while out_valid & !out_ready.
  - Each out_valid & out_ready advances the index. The handshake with out_last returns to LOAD_A; out_valid drops the next cycle.
- Latency: last B beat accepted at edge T. COMPUTE occupies T+1..T+N^3. out_valid first high in cycle T+N^3+1 (T+65 at default).
- Arithmetic:
  - Unsigned throughout. Products are 2*DATA_W bits; the accumulator is ACC_W bits and never overflows.
  - C stored as ACC_W bits. out_data is the low OUT_W bits (modulo 2^OUT_W) unless MATMUL_SAT_EN is defined.
- Boundaries:
  - in_valid held high across LOAD_A->LOAD_B: no beat lost, no beat duplicated.
  - out_ready held high: one element per cycle, N*N consecutive cycles.
  - out_ready low indefinitely: FSM stalls in OUTPUT; buffers unchanged.
  - rst mid-operation, any state: next edge returns to LOAD_A, partial operands discarded, out_valid=0 the following cycle.
  - A new operand stream is not accepted until OUTPUT completes. No overlap.

Optional Feature:
MATMUL_SAT_EN
- Defined: out_data = (C[i][j] > 2^OUT_W-1) ? {OUT_W{1'b1}} : C[i][j][OUT_W-1:0]. Saturation is applied at output time; stored C is unchanged.
- Undefined: out_data is plain truncation to the low OUT_W bits.
- Cycle timing is identical in both builds.

Test Plan:
1. A=identity, B[r][c]=4r+c+1, out_ready=1 -> out_data sequence 1..16, out_last only on the 16th beat.
2. A=B=all 255 -> every out_data=0xF804 (63492, truncated 260100). With MATMUL_SAT_EN -> every out_data=0xFFFF.
3. Latency: in_valid=1 continuously for 32 beats, last accepted at edge T -> out_valid first high at T+65, busy high from T+1.
4. Backpressure: A=B=all 2 (C=16), out_ready toggled 1,0,0,1,... -> 16 transfers of value 16; out_data and out_last stable during stalls; no loss.
5. Reset mid-COMPUTE: assert rst for 1 cycle at cycle 30 of COMPUTE -> out_valid stays 0, in_ready=1 after release. A subsequent full load of A=identity, B=all 7 yields 16 outputs of 7.
6. in_valid=1 with garbage data throughout COMPUTE and OUTPUT -> in_ready=0, results unaffected, next load starts cleanly at A[0][0].

Source files
------------

// File: rtl/matmul_seq_ctrl_if.sv
// Operand-in / result-out stream bundle for matmul_seq_ctrl.
// The host side uses the master modport and the controller uses the slave modport.
interface matmul_seq_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;
   logic              out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Time-multiplexed N x N matrix multiply: load A, load B, one MAC per cycle, stream C row-major.
// Optional build macro MATMUL_SAT_EN saturates out_data instead of truncating it.
module matmul_seq_ctrl #(
   parameter int  N      = 4,
   parameter int  DATA_W = 8,
   parameter int  OUT_W  = 16,
   localparam int ACC_W  = 2*DATA_W + $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   matmul_seq_ctrl_if.slave bus,
   output logic             busy
);
   localparam int L  = $clog2(N);
   localparam int NN = N*N;

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      COMPUTE = 2'd2,
      OUTPUT  = 2'd3
   } state_t;

   state_t            state_r, nextState_s;
   logic [2*L-1:0]    elemIdx_r;
   logic [3*L-1:0]    stepIdx_r;
   logic [ACC_W-1:0]  acc_r;
   logic [DATA_W-1:0] aBuf_r [NN];
   logic [DATA_W-1:0] bBuf_r [NN];
   logic [ACC_W-1:0]  cBuf_r [NN];
   logic              inReady_r, outValid_r, outLast_r, busy_r;
   logic [OUT_W-1:0]  outData_r;

   logic [L-1:0]        rowI_s, colJ_s, kIdx_s;
   logic                inFire_s, outFire_s, lastElem_s, lastStep_s;
   logic [2*DATA_W-1:0] prod_s;
   logic [ACC_W-1:0]    sum_s;
   logic [2*L-1:0]      nextElem_s, outSel_s;
   logic                nextInReady_s, nextOutValid_s, nextOutLast_s, nextBusy_s;
   logic [OUT_W-1:0]    nextOutData_s;

   function automatic logic [OUT_W-1:0] fmtOut(input logic [ACC_W-1:0] c);
      logic [ACC_W+OUT_W-1:0] wide;
      wide = {{OUT_W{1'b0}}, c};
`ifdef MATMUL_SAT_EN
      if (wide > {{ACC_W{1'b0}}, {OUT_W{1'b1}}}) begin
         fmtOut = {OUT_W{1'b1}};
      end else begin
         fmtOut = wide[OUT_W-1:0];
      end
`else
      fmtOut = wide[OUT_W-1:0];
`endif
   endfunction

   // Step decode and the shared multiply-accumulate; stepIdx packs {i, j, k} with k fastest
   always_comb begin
      rowI_s     = stepIdx_r[3*L-1:2*L];
      colJ_s     = stepIdx_r[2*L-1:L];
      kIdx_s     = stepIdx_r[L-1:0];
      inFire_s   = bus.in_valid & inReady_r;
      outFire_s  = outValid_r & bus.out_ready;
      lastElem_s = (elemIdx_r == {(2*L){1'b1}});
      lastStep_s = (stepIdx_r == {(3*L){1'b1}});
      prod_s     = aBuf_r[{rowI_s, kIdx_s}] * bBuf_r[{kIdx_s, colJ_s}];
      sum_s      = ((kIdx_s == {L{1'b0}}) ? {ACC_W{1'b0}} : acc_r)
                   + {{(ACC_W-2*DATA_W){1'b0}}, prod_s};
      nextElem_s = elemIdx_r + {{(2*L-1){1'b0}}, 1'b1};
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= LOAD_A;
      end else begin
         state_r <= nextState_s;
      end
   end

   // Next-state logic
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         LOAD_A: begin
            if (inFire_s && lastElem_s) nextState_s = LOAD_B;
            else                        nextState_s = LOAD_A;
         end
         LOAD_B: begin
            if (inFire_s && lastElem_s) nextState_s = COMPUTE;
            else                        nextState_s = LOAD_B;
         end
         COMPUTE: begin
            if (lastStep_s) nextState_s = OUTPUT;
            else            nextState_s = COMPUTE;
         end
         OUTPUT: begin
            if (outFire_s && outLast_r) nextState_s = LOAD_A;
            else                        nextState_s = OUTPUT;
         end
         default: nextState_s = LOAD_A;
      endcase
   end

   // Next values of the registered outputs; the result selector starts at 0 on OUTPUT entry
   always_comb begin
      nextInReady_s  = (nextState_s == LOAD_A) || (nextState_s == LOAD_B);
      nextBusy_s     = (nextState_s == COMPUTE) || (nextState_s == OUTPUT);
      nextOutValid_s = (nextState_s == OUTPUT);
      if (state_r != OUTPUT) begin
         outSel_s = {(2*L){1'b0}};
      end else if (outFire_s) begin
         outSel_s = nextElem_s;
      end else begin
         outSel_s = elemIdx_r;
      end
      if (nextState_s == OUTPUT) begin
         nextOutData_s = fmtOut(cBuf_r[outSel_s]);
         nextOutLast_s = (outSel_s == {(2*L){1'b1}});
      end else begin
         nextOutData_s = outData_r;
         nextOutLast_s = 1'b0;
      end
   end

   // Counters, accumulator and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         elemIdx_r  <= {(2*L){1'b0}};
         stepIdx_r  <= {(3*L){1'b0}};
         acc_r      <= {ACC_W{1'b0}};
         inReady_r  <= 1'b1;
         outValid_r <= 1'b0;
         outLast_r  <= 1'b0;
         outData_r  <= {OUT_W{1'b0}};
         busy_r     <= 1'b0;
      end else begin
         inReady_r  <= nextInReady_s;
         outValid_r <= nextOutValid_s;
         outLast_r  <= nextOutLast_s;
         outData_r  <= nextOutData_s;
         busy_r     <= nextBusy_s;
         case (state_r)
            LOAD_A, LOAD_B: begin
               if (inFire_s) elemIdx_r <= nextElem_s;
            end
            COMPUTE: begin
               acc_r     <= sum_s;
               stepIdx_r <= stepIdx_r + {{(3*L-1){1'b0}}, 1'b1};
            end
            OUTPUT: begin
               if (outFire_s) elemIdx_r <= nextElem_s;
            end
            default: ;
         endcase
      end
   end

   // Operand and result buffers; stale contents are harmless because the counters restart at 0
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state_r == LOAD_A && inFire_s) aBuf_r[elemIdx_r] <= bus.in_data;
         if (state_r == LOAD_B && inFire_s) bBuf_r[elemIdx_r] <= bus.in_data;
         if (state_r == COMPUTE && kIdx_s == {L{1'b1}}) cBuf_r[{rowI_s, colJ_s}] <= sum_s;
      end
   end

   // In-ready is also forced low for as long as reset is held
   assign bus.in_ready  = inReady_r & ~rst;
   assign bus.out_valid = outValid_r;
   assign bus.out_data  = outData_r;
   assign bus.out_last  = outLast_r;
   assign busy          = busy_r;
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Randomised bench for matmul_seq_ctrl against a plain-arithmetic matrix product model.
module tb_matmul_seq_ctrl;
   localparam int N = 4, DW = 8, OW = 16, NN = N*N;
`ifdef MATMUL_SAT_EN
   localparam int EXP_ALL255 = 65535;
`else
   localparam int EXP_ALL255 = 63492;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   always #5 clk = ~clk;

   matmul_seq_ctrl_if #(.DATA_W(DW), .OUT_W(OW)) bus ();
   matmul_seq_ctrl #(.N(N), .DATA_W(DW), .OUT_W(OW)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy)
   );

   int matA [NN];
   int matB [NN];
   int expOut [NN];
   logic [OW-1:0] gotData [NN];
   logic gotLast [NN];
   int nTests = 0;
   int nFail = 0;
   int cycleCnt = 0;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void build_model();
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            longint s = 0;
            for (int k = 0; k < N; k++) s += longint'(matA[i*N+k]) * longint'(matB[k*N+j]);
`ifdef MATMUL_SAT_EN
            expOut[i*N+j] = (s > 65535) ? 65535 : int'(s);
`else
            expOut[i*N+j] = int'(s % 65536);
`endif
         end
      end
   endfunction

   task automatic drive_operands(input bit gaps, input bit holdGarbage, output int tEdge, output bit to);
      int idx = 0;
      int cyc = 0;
      bit v, accepted;
      tEdge = 0;
      while (idx < 2*NN && cyc < 2000) begin
         v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.in_valid = v;
         bus.in_data  = v ? DW'(idx < NN ? matA[idx] : matB[idx-NN]) : DW'($urandom);
         accepted = v && (bus.in_ready === 1'b1);
         step();
         cyc++;
         if (accepted) begin
            idx++;
            if (idx == 2*NN) tEdge = cycleCnt;
         end
      end
      to = (idx < 2*NN);
      bus.in_valid = holdGarbage;
      bus.in_data  = DW'($urandom);
   endtask

   // mode 0: ready always, 1: random ready, 2: ready pattern 1,0,0 repeating
   task automatic collect_out(input int mode, input bit garbage, output int nOut, output int firstValid,
                              output int lastEdge, output int badStable, output int badInReady, output bit to);
      int cyc = 0;
      bit rdy, pend, done;
      logic [OW-1:0] pData;
      logic pLast;
      nOut = 0; firstValid = -1; lastEdge = -1; badStable = 0; badInReady = 0;
      pend = 1'b0; done = 1'b0; pData = '0; pLast = 1'b0;
      while (!done && cyc < 3000 && nOut <= NN) begin
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (cyc % 3 == 0);
         endcase
         bus.out_ready = rdy;
         if (garbage) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'($urandom);
         end
         if (bus.in_ready !== 1'b0) badInReady++;
         if (bus.out_valid === 1'b1 && firstValid < 0) firstValid = cycleCnt;
         if (pend && (bus.out_valid !== 1'b1 || bus.out_data !== pData || bus.out_last !== pLast)) badStable++;
         pend  = (bus.out_valid === 1'b1) && !rdy;
         pData = bus.out_data;
         pLast = bus.out_last;
         if (bus.out_valid === 1'b1 && rdy) begin
            if (nOut < NN) begin
               gotData[nOut] = bus.out_data;
               gotLast[nOut] = bus.out_last;
            end
            nOut++;
            if (bus.out_last === 1'b1) done = 1'b1;
         end
         step();
         cyc++;
      end
      lastEdge = cycleCnt;
      bus.out_ready = 1'b0;
      if (garbage) bus.in_valid = 1'b0;
      to = !done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      repeat (3) step();
      nTests++; if (bus.out_valid !== 1'b0) begin nFail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      nTests++; if (bus.out_last !== 1'b0) begin nFail++; $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
      nTests++; if (bus.out_data !== 16'd0) begin nFail++; $display("FAIL reset_out_data: got %0d expected 0", bus.out_data); end
      nTests++; if (busy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      nTests++; if (bus.in_ready !== 1'b0) begin nFail++; $display("FAIL reset_in_ready_held: got %b expected 0", bus.in_ready); end
      rst = 1'b0;
      #1;
      nTests++; if (bus.in_ready !== 1'b1) begin nFail++; $display("FAIL reset_in_ready_release: got %b expected 1", bus.in_ready); end
   endtask

   task automatic test_identity();
      int tEdge, nOut, fv, le, bs, bi;
      bit to1, to2;
      for (int i = 0; i < NN; i++) begin
         matA[i] = (i / N == i % N) ? 1 : 0;
         matB[i] = i + 1;
      end
      drive_operands(1'b0, 1'b0, tEdge, to1);
      collect_out(0, 1'b0, nOut, fv, le, bs, bi, to2);
      nTests++; if (to1 || to2) begin nFail++; $display("FAIL identity_timeout: got load=%b out=%b expected 0 0", to1, to2); end
      nTests++; if (nOut != NN) begin nFail++; $display("FAIL identity_count: got %0d expected %0d", nOut, NN); end
      for (int i = 0; i < NN; i++) begin
         nTests++;
         if (gotData[i] !== OW'(i + 1) || gotLast[i] !== (i == NN-1)) begin
            nFail++;
            $display("FAIL identity_elem%0d: got %0d last=%b expected %0d last=%b", i, gotData[i], gotLast[i], i + 1, i == NN-1);
         end
      end
      nTests++; if (le - fv != NN) begin nFail++; $display("FAIL identity_streaming_cycles: got %0d expected %0d", le - fv, NN); end
      nTests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         nFail++; $display("FAIL identity_return_load: got valid=%b ready=%b expected 0 1", bus.out_valid, bus.in_ready); end
   endtask

   task automatic test_all255();
      int tEdge, nOut, fv, le, bs, bi;
      bit to1, to2;
      for (int i = 0; i < NN; i++) begin matA[i] = 255; matB[i] = 255; end
      build_model();
      drive_operands(1'b0, 1'b0, tEdge, to1);
      collect_out(0, 1'b0, nOut, fv, le, bs, bi, to2);
      nTests++; if (to1 || to2 || nOut != NN) begin nFail++; $display("FAIL all255_count: got %0d expected %0d", nOut, NN); end
      for (int i = 0; i < NN; i++) begin
         nTests++;
         if (gotData[i] !== OW'(EXP_ALL255) || gotData[i] !== OW'(expOut[i])) begin
            nFail++; $display("FAIL all255_elem%0d: got %0d expected %0d", i, gotData[i], EXP_ALL255);
         end
      end
   endtask

   task automatic test_latency();
      int tEdge, nOut, fv, le, bs, bi;
      bit to1, to2;
      for (int i = 0; i < NN; i++) begin matA[i] = $urandom_range(0, 255); matB[i] = $urandom_range(0, 255); end
      build_model();
      drive_operands(1'b0, 1'b0, tEdge, to1);
      nTests++; if (busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         nFail++; $display("FAIL latency_compute_entry: got busy=%b valid=%b ready=%b expected 1 0 0", busy, bus.out_valid, bus.in_ready); end
      collect_out(0, 1'b0, nOut, fv, le, bs, bi, to2);
      // out_valid is seen just after edge T+N^3, i.e. during cycle T+N^3+1
      nTests++; if (to1 || to2 || fv != tEdge + N*N*N) begin
         nFail++; $display("FAIL latency_first_valid: got %0d expected %0d", fv - tEdge, N*N*N); end
      for (int i = 0; i < NN; i++) begin
         nTests++;
         if (gotData[i] !== OW'(expOut[i])) begin nFail++; $display("FAIL latency_elem%0d: got %0d expected %0d", i, gotData[i], expOut[i]); end
      end
   endtask

   task automatic test_backpressure();
      int tEdge, nOut, fv, le, bs, bi;
      bit to1, to2;
      for (int i = 0; i < NN; i++) begin matA[i] = 2; matB[i] = 2; end
      drive_operands(1'b1, 1'b0, tEdge, to1);
      collect_out(2, 1'b0, nOut, fv, le, bs, bi, to2);
      nTests++; if (to1 || to2 || nOut != NN) begin nFail++; $display("FAIL backpressure_count: got %0d expected %0d", nOut, NN); end
      nTests++; if (bs != 0) begin nFail++; $display("FAIL backpressure_stable: got %0d unstable stalls expected 0", bs); end
      for (int i = 0; i < NN; i++) begin
         nTests++;
         if (gotData[i] !== 16'd16 || gotLast[i] !== (i == NN-1)) begin
            nFail++; $display("FAIL backpressure_elem%0d: got %0d last=%b expected 16 last=%b", i, gotData[i], gotLast[i], i == NN-1); end
      end
   endtask

   task automatic test_reset_mid_compute();
      int tEdge, nOut, fv, le, bs, bi, seenValid;
      bit to1, to2;
      for (int i = 0; i < NN; i++) begin matA[i] = $urandom_range(0, 255); matB[i] = $urandom_range(0, 255); end
      drive_operands(1'b0, 1'b0, tEdge, to1);
      repeat (29) step();
      rst = 1'b1;
      step();
      nTests++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
         nFail++; $display("FAIL midreset_state: got valid=%b busy=%b ready=%b expected 0 0 0", bus.out_valid, busy, bus.in_ready); end
      rst = 1'b0;
      #1;
      nTests++; if (bus.in_ready !== 1'b1) begin nFail++; $display("FAIL midreset_in_ready: got %b expected 1", bus.in_ready); end
      seenValid = 0;
      for (int c = 0; c < 80; c++) begin
         step();
         if (bus.out_valid !== 1'b0) seenValid++;
      end
      nTests++; if (seenValid != 0) begin nFail++; $display("FAIL midreset_no_output: got %0d valid cycles expected 0", seenValid); end
      for (int i = 0; i < NN; i++) begin matA[i] = (i / N == i % N) ? 1 : 0; matB[i] = 7; end
      drive_operands(1'b0, 1'b0, tEdge, to1);
      collect_out(1, 1'b0, nOut, fv, le, bs, bi, to2);
      nTests++; if (to1 || to2 || nOut != NN) begin nFail++; $display("FAIL midreset_reload_count: got %0d expected %0d", nOut, NN); end
      for (int i = 0; i < NN; i++) begin
         nTests++;
         if (gotData[i] !== 16'd7) begin nFail++; $display("FAIL midreset_elem%0d: got %0d expected 7", i, gotData[i]); end
      end
   endtask

   task automatic test_garbage_input();
      int tEdge, nOut, fv, le, bs, bi;
      bit to1, to2;
      for (int i = 0; i < NN; i++) begin matA[i] = $urandom_range(0, 255); matB[i] = $urandom_range(0, 255); end
      build_model();
      drive_operands(1'b1, 1'b1, tEdge, to1);
      collect_out(1, 1'b1, nOut, fv, le, bs, bi, to2);
      nTests++; if (bi != 0) begin nFail++; $display("FAIL garbage_in_ready: got %0d cycles ready expected 0", bi); end
      nTests++; if (to1 || to2 || nOut != NN) begin nFail++; $display("FAIL garbage_count: got %0d expected %0d", nOut, NN); end
      for (int i = 0; i < NN; i++) begin
         nTests++;
         if (gotData[i] !== OW'(expOut[i])) begin nFail++; $display("FAIL garbage_elem%0d: got %0d expected %0d", i, gotData[i], expOut[i]); end
      end
      for (int i = 0; i < NN; i++) begin matA[i] = (i / N == i % N) ? 1 : 0; matB[i] = $urandom_range(0, 255); end
      drive_operands(1'b0, 1'b0, tEdge, to1);
      collect_out(0, 1'b0, nOut, fv, le, bs, bi, to2);
      for (int i = 0; i < NN; i++) begin
         nTests++;
         if (to1 || to2 || gotData[i] !== OW'(matB[i])) begin
            nFail++; $display("FAIL garbage_clean_reload%0d: got %0d expected %0d", i, gotData[i], matB[i]); end
      end
   endtask

   task automatic test_random();
      int tEdge, nOut, fv, le, bs, bi, bad;
      bit to1, to2;
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < NN; i++) begin matA[i] = $urandom_range(0, 255); matB[i] = $urandom_range(0, 255); end
         build_model();
         drive_operands(1'b1, 1'b0, tEdge, to1);
         collect_out(1, 1'b0, nOut, fv, le, bs, bi, to2);
         bad = 0;
         for (int i = 0; i < NN; i++) if (gotData[i] !== OW'(expOut[i]) || gotLast[i] !== (i == NN-1)) bad++;
         nTests++; if (to1 || to2 || nOut != NN || bad != 0 || bs != 0) begin
            nFail++; $display("FAIL random_iter%0d: got %0d outputs %0d wrong %0d unstable expected %0d 0 0", it, nOut, bad, bs, NN); end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      test_reset();
      test_identity();
      test_all255();
      test_latency();
      test_backpressure();
      test_reset_mid_compute();
      test_garbage_input();
      test_random();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
